// File: rtl/module_lcd_controller.sv
// module_lcd_controller: display-request receiver driving an HD44780 16x2 LCD
// in 8-bit write-only mode. Runs the LCD power-up init itself, then renders a
// two-line frame (mnemonic/register on line 1, result on line 2) per request.
// Optional feature: define LCD_HEX_VALUE_EN to show line 2 as raw hex and
// skip the binary-to-BCD conversion state.
module module_lcd_controller #(
  parameter int unsigned POWERUP_CYC = 1_000_000,
  parameter int unsigned E_CYC       = 12,
  parameter int unsigned CMD_CYC     = 2_000,
  parameter int unsigned CLR_CYC     = 100_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [2:0]  opcode,
  input  logic [3:0]  addr,
  input  logic [15:0] value,
  output logic        ack,
  output logic        busy,
  output logic        done,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_e,
  output logic [7:0]  lcd_data
);

  typedef enum logic [2:0] {S_PWRUP, S_INIT, S_IDLE, S_CONV, S_WRITE} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_E, PH_HOLD} phase_t;

  localparam logic [5:0] INIT_LAST  = 6'd3;
  localparam logic [5:0] FRAME_LAST = 6'd33;

  state_t      state, state_nxt;
  phase_t      phase, phase_nxt;
  logic [5:0]  idx, idx_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic [31:0] hold_len;
  logic        last_byte;
  logic        done_q;

  logic [2:0]  op_q;
  logic [3:0]  addr_q;
`ifdef LCD_HEX_VALUE_EN
  logic [15:0] value_q;
`else
  logic        sign_q;
  logic [15:0] bin_q;
  logic [19:0] bcd_q;
  logic [19:0] bcd_adj;
`endif

  logic [3:0]  l1_pos, l2_pos;
  logic [7:0]  line2_byte;
  logic [7:0]  cur_byte;
  logic        cur_rs;

  function automatic logic [39:0] mnemonic(input logic [2:0] op);
    case (op)
      3'd0:    return "LOAD ";
      3'd1:    return "ADD  ";
      3'd2:    return "ADDI ";
      3'd3:    return "SUB  ";
      3'd4:    return "SUBI ";
      3'd5:    return "MUL  ";
      3'd6:    return "CLEAR";
      default: return "DISP ";
    endcase
  endfunction

  function automatic logic [7:0] dec_char(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

`ifdef LCD_HEX_VALUE_EN
  function automatic logic [7:0] hex_char(input logic [3:0] d);
    return (d < 4'd10) ? 8'h30 + {4'h0, d} : 8'h37 + {4'h0, d};
  endfunction
`else
  // Double-dabble correction: every BCD digit >= 5 gets +3 before the shift.
  function automatic logic [19:0] dd_adjust(input logic [19:0] b);
    logic [19:0] r;
    for (int k = 0; k < 5; k++)
      r[4*k +: 4] = (b[4*k +: 4] >= 4'd5) ? b[4*k +: 4] + 4'd3 : b[4*k +: 4];
    return r;
  endfunction

  assign bcd_adj = dd_adjust(bcd_q);
`endif

  function automatic logic [7:0] line1_char(input logic [3:0] p, input logic [2:0] op,
                                            input logic [3:0] a);
    logic [39:0] mn;
    mn = mnemonic(op);
    case (p)
      4'd0:    return mn[39:32];
      4'd1:    return mn[31:24];
      4'd2:    return mn[23:16];
      4'd3:    return mn[15:8];
      4'd4:    return mn[7:0];
      4'd6:    return "R";
      4'd7:    return (a >= 4'd10) ? "1" : "0";
      4'd8:    return dec_char((a >= 4'd10) ? a - 4'd10 : a);
      default: return " ";
    endcase
  endfunction

  assign l1_pos = 4'(idx - 6'd1);
  assign l2_pos = 4'(idx - 6'd18);

  // Line-2 character for the current position (decimal or hex rendering).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    line2_byte = " ";
    case (l2_pos)
      4'd0: line2_byte = "=";
`ifdef LCD_HEX_VALUE_EN
      4'd1: line2_byte = "0";
      4'd2: line2_byte = "x";
      4'd3: line2_byte = hex_char(value_q[15:12]);
      4'd4: line2_byte = hex_char(value_q[11:8]);
      4'd5: line2_byte = hex_char(value_q[7:4]);
      4'd6: line2_byte = hex_char(value_q[3:0]);
`else
      4'd1: line2_byte = sign_q ? "-" : "+";
      4'd2: line2_byte = dec_char(bcd_q[19:16]);
      4'd3: line2_byte = dec_char(bcd_q[15:12]);
      4'd4: line2_byte = dec_char(bcd_q[11:8]);
      4'd5: line2_byte = dec_char(bcd_q[7:4]);
      4'd6: line2_byte = dec_char(bcd_q[3:0]);
`endif
      default: line2_byte = " ";
    endcase
  end

  // Byte currently on the bus: init command sequence or frame byte.
  always_comb begin
    cur_byte = 8'h00;
    cur_rs   = 1'b0;
    if (state == S_INIT) begin
      case (idx[1:0])
        2'd0:    cur_byte = 8'h38;
        2'd1:    cur_byte = 8'h0C;
        2'd2:    cur_byte = 8'h01;
        default: cur_byte = 8'h06;
      endcase
    end else if (state == S_WRITE) begin
      if (idx == 6'd0) begin
        cur_byte = 8'h80;
      end else if (idx <= 6'd16) begin
        cur_rs   = 1'b1;
        cur_byte = line1_char(l1_pos, op_q, addr_q);
      end else if (idx == 6'd17) begin
        cur_byte = 8'hC0;
      end else begin
        cur_rs   = 1'b1;
        cur_byte = line2_byte;
      end
    end
  end

  // Next-state logic: power-up wait, byte strobe sequencing, request accept, conversion.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    idx_nxt   = idx;
    cnt_nxt   = cnt + 32'd1;
    // Clear-display needs the long post-byte hold; everything else the short one.
    hold_len  = (cur_byte == 8'h01 && !cur_rs) ? CLR_CYC : CMD_CYC;
    last_byte = (state == S_INIT) ? (idx == INIT_LAST) : (idx == FRAME_LAST);
    case (state)
      S_PWRUP: begin
        if (cnt == POWERUP_CYC - 1) begin
          state_nxt = S_INIT;
          phase_nxt = PH_SETUP;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      S_INIT, S_WRITE: begin
        case (phase)
          PH_SETUP: begin
            phase_nxt = PH_E;
            cnt_nxt   = '0;
          end
          PH_E: begin
            if (cnt == E_CYC - 1) begin
              phase_nxt = PH_HOLD;
              cnt_nxt   = '0;
            end
          end
          default: begin
            if (cnt == hold_len - 1) begin
              phase_nxt = PH_SETUP;
              cnt_nxt   = '0;
              if (last_byte) begin
                state_nxt = S_IDLE;
                idx_nxt   = '0;
              end else begin
                idx_nxt   = idx + 6'd1;
              end
            end
          end
        endcase
      end
      S_IDLE: begin
        cnt_nxt = '0;
        if (req) begin
`ifdef LCD_HEX_VALUE_EN
          state_nxt = S_WRITE;
`else
          state_nxt = S_CONV;
`endif
          phase_nxt = PH_SETUP;
          idx_nxt   = '0;
        end
      end
      S_CONV: begin
        if (cnt == 32'd15) begin
          state_nxt = S_WRITE;
          phase_nxt = PH_SETUP;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = S_PWRUP;
    endcase
  end

  // FSM state register and per-phase counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_PWRUP;
      phase <= PH_SETUP;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      state <= state_nxt;
      phase <= phase_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Request latch, binary-to-BCD shifter and end-of-frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q  <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
`ifdef LCD_HEX_VALUE_EN
      value_q <= '0;
`else
      sign_q  <= 1'b0;
      bin_q   <= '0;
      bcd_q   <= '0;
`endif
    end else begin
      done_q <= (state == S_WRITE) && (state_nxt == S_IDLE);
      if (ack) begin
        op_q    <= opcode;
        addr_q  <= addr;
`ifdef LCD_HEX_VALUE_EN
        value_q <= value;
`else
        sign_q  <= value[15];
        // 16'h8000 negates to itself, which read unsigned is the required 32768.
        bin_q   <= value[15] ? (~value + 16'd1) : value;
        bcd_q   <= '0;
      end else if (state == S_CONV) begin
        bcd_q   <= (bcd_adj << 1) | {19'd0, bin_q[15]};
        bin_q   <= bin_q << 1;
`endif
      end
    end
  end

  assign ack      = (state == S_IDLE) && req;
  assign busy     = (state != S_IDLE);
  assign done     = done_q;
  assign lcd_rw   = 1'b0;
  assign lcd_e    = (phase == PH_E) && (state == S_INIT || state == S_WRITE);
  assign lcd_rs   = cur_rs;
  assign lcd_data = cur_byte;

endmodule
